key_repeat_ctrl: RTL and testbench
==================================

# key_repeat_ctrl

Converts the four raw DE1-SoC push-buttons into clean, single-cycle game-move pulses for the Tetris core. It sits directly downstream of the 10 ms input tick generator: raw KEY lines are synchronised, debounced on tick boundaries, and passed through a per-button delayed-auto-repeat FSM. The outputs feed the piece-movement logic alongside the gravity tick.

## Interface
- DEB_TICKS, 3 — consecutive identical tick samples required to change a debounced key state (≥1).
- DAS_TICKS, 17 — ticks from first press pulse to first repeat pulse (≥1).
- ARR_TICKS, 5 — ticks between subsequent repeat pulses (≥1).
- REPEAT_MASK, 4'b1110 — per-key auto-repeat enable; bit i corresponds to KEY[i].

- CLOCK_50  in  1  system clock, 50 MHz.
- resetn  in  1  reset, asynchronous, active-low.
- tick_input  in  1  one-cycle sample strobe, nominally every 500 000 cycles.
- game_active  in  1  1 = pulses allowed; 0 = all FSMs forced to IDLE, outputs 0.
- KEY  in  4  raw buttons, active-low: [0] rotate, [1] down, [2] right, [3] left.
- rotate  out  1  one-cycle pulse.
- move_down  out  1  one-cycle pulse.
- move_right  out  1  one-cycle pulse.
- move_left  out  1  one-cycle pulse.

## Operation
- Per key: 2-flop synchroniser on CLOCK_50, inverted so 1 = pressed.
- Debounce (tick edges only): if synced sample ≠ stable state, increment count; else clear count. When count would reach DEB_TICKS, toggle stable and clear count. A single disagreeing sample (bounce) clears count.
- Repeat FSM per key, states IDLE, DELAY, REPEAT; down-counter wide enough for max(DAS_TICKS, ARR_TICKS).
  - IDLE: on stable 0→1 with game_active=1: emit pulse, load DAS_TICKS, go to DELAY if REPEAT_MASK[i], else to REPEAT with the counter frozen (no further pulses).
  - DELAY/REPEAT: on each tick edge decrement; on the tick edge where counter==1, emit pulse, reload ARR_TICKS, go to REPEAT.
  - Any state: stable=0 → IDLE, no pulse. game_active=0 → IDLE, pulse suppressed.
- Re-enabling game_active while a key is held produces no pulse; the key must be released and re-pressed, since no stable rising edge occurs.
- Left/right conflict: in any cycle where both left and right stable states are 1, move_left and move_right are forced 0. FSM timing continues unaffected.
- Reset: synchronisers and stable states = released, counts 0, all FSMs IDLE, all outputs 0. Reset mid-hold also returns the key to released; a still-held key must re-debounce (DEB_TICKS ticks) before it pulses.

## Timing
- Outputs are registered, high for exactly one CLOCK_50 cycle, never on consecutive cycles.
- Stable state flips on the tick edge that takes the DEB_TICKS-th consecutive differing sample. The first pulse is high in the cycle after the next clock edge, i.e. 2 edges after that tick edge.
- Press latency from a clean KEY edge: 2 cycles (sync) + DEB_TICKS tick periods + 2 cycles.
- First repeat occurs DAS_TICKS tick edges after the first pulse. Subsequent repeats occur every ARR_TICKS tick edges, registered one cycle after that tick edge.
- A tick landing in the same cycle as the first-pulse edge does not decrement the freshly loaded counter.
- Release does not cancel a pulse already registered.

## Test plan
- Reset: hold resetn=0 with KEY=4'b0000 → all outputs 0. Release resetn with KEY=4'b1111 → no pulse for ≥50 ticks.
- Clean press of KEY[2], held 10 ticks (DEB=3), tick every 20 cycles → exactly one move_right pulse, on the 2nd edge after the 3rd pressed tick edge. No repeat before release.
- Bounce: KEY[0] toggles on alternate ticks for 8 ticks, then held → no rotate during the bounce. Exactly one rotate after 3 stable ticks. None thereafter (REPEAT_MASK[0]=0).
- Auto-repeat: hold KEY[1] for 40 ticks → move_down pulses at first pulse, then +17 ticks, +22, +27, +32, +37 (6 pulses). Release → none.
- Conflict: press KEY[3], then KEY[2] while held → move_left pulses until KEY[2] is debounced, then neither. Release KEY[2] → left resumes on its own repeat schedule.
- game_active drops to 0 during DELAY → no pulses. Raise to 1 while the key is still held → no pulse. Release and re-press → one pulse.

Source files
------------

// File: rtl/key_repeat_ctrl.sv
// Push-button front end: sync, tick-based debounce and delayed auto-repeat
// per key, producing one-cycle move pulses for the game core.
module key_repeat_ctrl #(
    parameter int         DEB_TICKS   = 3,
    parameter int         DAS_TICKS   = 17,
    parameter int         ARR_TICKS   = 5,
    parameter logic [3:0] REPEAT_MASK = 4'b1110
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       tick_input,
    input  logic       game_active,
    input  logic [3:0] KEY,
    output logic       rotate,
    output logic       move_down,
    output logic       move_right,
    output logic       move_left
);

    localparam int MAXT = (DAS_TICKS > ARR_TICKS) ? DAS_TICKS : ARR_TICKS;
    localparam int CW   = $clog2(MAXT + 1);
    localparam int DW   = $clog2(DEB_TICKS + 1);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } state_t;

    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [3:0]    stable;
    logic [3:0]    stable_d;
    logic [3:0]    pulse;
    logic [DW-1:0] deb_cnt [4];
    logic [CW-1:0] cnt     [4];
    state_t        state   [4];
    logic          conflict;

    // Inverted so that 1 means pressed from here on
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= ~KEY;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            stable <= '0;
            for (int i = 0; i < 4; i++) begin
                deb_cnt[i] <= '0;
            end
        end else if (tick_input) begin
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] != stable[i]) begin
                    if (deb_cnt[i] == DW'(DEB_TICKS - 1)) begin
                        stable[i]  <= ~stable[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // Keys without repeat park in REPEAT with the counter frozen
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            stable_d <= '0;
            pulse    <= '0;
            for (int i = 0; i < 4; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
            end
        end else begin
            stable_d <= stable;
            for (int i = 0; i < 4; i++) begin
                pulse[i] <= 1'b0;
                if (!game_active || !stable[i]) begin
                    state[i] <= IDLE;
                end else begin
                    case (state[i])
                        IDLE: begin
                            if (!stable_d[i]) begin
                                pulse[i] <= 1'b1;
                                cnt[i]   <= CW'(DAS_TICKS);
                                state[i] <= REPEAT_MASK[i] ? DELAY : REPEAT;
                            end
                        end
                        DELAY, REPEAT: begin
                            if (tick_input &&
                                (state[i] == DELAY || REPEAT_MASK[i])) begin
                                if (cnt[i] == CW'(1)) begin
                                    pulse[i] <= 1'b1;
                                    cnt[i]   <= CW'(ARR_TICKS);
                                    state[i] <= REPEAT;
                                end else begin
                                    cnt[i] <= cnt[i] - 1'b1;
                                end
                            end
                        end
                        default: state[i] <= IDLE;
                    endcase
                end
            end
        end
    end

    assign conflict = stable[3] & stable[2];

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            rotate     <= 1'b0;
            move_down  <= 1'b0;
            move_right <= 1'b0;
            move_left  <= 1'b0;
        end else begin
            rotate     <= pulse[0];
            move_down  <= pulse[1];
            move_right <= pulse[2] & ~conflict;
            move_left  <= pulse[3] & ~conflict;
        end
    end

endmodule

// File: tb/tb_key_repeat_ctrl.sv
// Directed bench for key_repeat_ctrl: debounce latency, repeat schedule,
// conflict masking, game_active gating and reset behaviour.
module tb_key_repeat_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic       tick_input;
    logic       game_active;
    logic [3:0] KEY;
    logic       rotate;
    logic       move_down;
    logic       move_right;
    logic       move_left;
    logic [3:0] outs;
    logic [3:0] prev = '0;

    int total = 0;
    int bad   = 0;
    int cyc = 0;
    int tick_num = 0;
    int last_tick_cyc = 0;
    int consec = 0;
    int n  [4] = '{0, 0, 0, 0};
    int pt [4][64];
    int pd [4][64];

    key_repeat_ctrl dut (
        .CLOCK_50    (clk),
        .resetn      (resetn),
        .tick_input  (tick_input),
        .game_active (game_active),
        .KEY         (KEY),
        .rotate      (rotate),
        .move_down   (move_down),
        .move_right  (move_right),
        .move_left   (move_left)
    );

    assign outs = {move_left, move_right, move_down, rotate};

    initial forever #10 clk = ~clk;

    // One-cycle tick every 20 clocks
    initial begin
        tick_input = 1'b0;
        forever begin
            repeat (19) @(negedge clk);
            tick_input = 1'b1;
            @(negedge clk);
            tick_input = 1'b0;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tick_input) begin
            tick_num      <= tick_num + 1;
            last_tick_cyc <= cyc + 1;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (outs[k]) begin
                if (n[k] < 64) begin
                    pt[k][n[k]] <= tick_num;
                    pd[k][n[k]] <= cyc - last_tick_cyc;
                end
                n[k] <= n[k] + 1;
                if (prev[k]) consec <= consec + 1;
            end
        end
        prev <= outs;
    end

    task automatic wait_ticks(input int cnt);
        repeat (cnt) begin
            @(posedge clk);
            while (!tick_input) @(posedge clk);
        end
        #1;
    endtask

    task automatic test_reset();
        resetn      = 1'b0;
        game_active = 1'b1;
        KEY         = 4'b0000;
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (outs !== 4'b0000) begin
            bad++;
            $display("FAIL reset_outs got=%b want=0000", outs);
        end
        KEY    = 4'b1111;
        resetn = 1'b1;
        wait_ticks(50);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (n[k] !== 0) begin
                bad++;
                $display("FAIL reset_idle_%0d got=%0d want=0", k, n[k]);
            end
        end
    endtask

    task automatic test_clean_press();
        int b, t0, others;
        b      = n[2];
        others = n[0] + n[1] + n[3];
        wait_ticks(1);
        t0 = tick_num;
        KEY[2] = 1'b0;
        wait_ticks(10);
        KEY[2] = 1'b1;
        wait_ticks(5);
        total++;
        if (n[2] - b !== 1) begin
            bad++;
            $display("FAIL press_count got=%0d want=1", n[2] - b);
        end
        total++;
        if (pt[2][b] !== t0 + 3) begin
            bad++;
            $display("FAIL press_tick got=%0d want=%0d", pt[2][b], t0 + 3);
        end
        total++;
        if (pd[2][b] !== 2) begin
            bad++;
            $display("FAIL press_lat got=%0d want=2", pd[2][b]);
        end
        total++;
        if (n[0] + n[1] + n[3] !== others) begin
            bad++;
            $display("FAIL press_others got=%0d want=%0d",
                     n[0] + n[1] + n[3], others);
        end
    endtask

    task automatic test_bounce();
        int b, t0;
        b = n[0];
        wait_ticks(1);
        for (int i = 0; i < 8; i++) begin
            KEY[0] = (i % 2 == 1);
            wait_ticks(1);
        end
        total++;
        if (n[0] !== b) begin
            bad++;
            $display("FAIL bounce_quiet got=%0d want=%0d", n[0], b);
        end
        t0 = tick_num;
        KEY[0] = 1'b0;
        wait_ticks(30);
        KEY[0] = 1'b1;
        wait_ticks(5);
        total++;
        if (n[0] - b !== 1) begin
            bad++;
            $display("FAIL bounce_count got=%0d want=1", n[0] - b);
        end
        total++;
        if (pt[0][b] !== t0 + 3) begin
            bad++;
            $display("FAIL bounce_tick got=%0d want=%0d", pt[0][b], t0 + 3);
        end
    endtask

    task automatic test_auto_repeat();
        int b, t0;
        int off [6];
        off = '{3, 20, 25, 30, 35, 40};
        b = n[1];
        wait_ticks(1);
        t0 = tick_num;
        KEY[1] = 1'b0;
        wait_ticks(40);
        KEY[1] = 1'b1;
        wait_ticks(8);
        total++;
        if (n[1] - b !== 6) begin
            bad++;
            $display("FAIL repeat_count got=%0d want=6", n[1] - b);
        end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (pt[1][b+i] !== t0 + off[i]) begin
                bad++;
                $display("FAIL repeat_tick_%0d got=%0d want=%0d",
                         i, pt[1][b+i], t0 + off[i]);
            end
            total++;
            if (pd[1][b+i] !== ((i == 0) ? 2 : 1)) begin
                bad++;
                $display("FAIL repeat_lat_%0d got=%0d want=%0d",
                         i, pd[1][b+i], (i == 0) ? 2 : 1);
            end
        end
    endtask

    task automatic test_conflict();
        int bl, br, t0;
        int off [5];
        off = '{3, 20, 25, 40, 45};
        bl = n[3];
        br = n[2];
        wait_ticks(1);
        t0 = tick_num;
        KEY[3] = 1'b0;
        wait_ticks(23);
        KEY[2] = 1'b0;
        wait_ticks(13);
        KEY[2] = 1'b1;
        wait_ticks(10);
        KEY[3] = 1'b1;
        wait_ticks(6);
        total++;
        if (n[2] !== br) begin
            bad++;
            $display("FAIL conflict_right got=%0d want=%0d", n[2], br);
        end
        total++;
        if (n[3] - bl !== 5) begin
            bad++;
            $display("FAIL conflict_left_count got=%0d want=5", n[3] - bl);
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (pt[3][bl+i] !== t0 + off[i]) begin
                bad++;
                $display("FAIL conflict_left_tick_%0d got=%0d want=%0d",
                         i, pt[3][bl+i], t0 + off[i]);
            end
        end
    endtask

    task automatic test_game_active();
        int b, t0;
        b = n[1];
        wait_ticks(1);
        t0 = tick_num;
        KEY[1] = 1'b0;
        wait_ticks(8);
        game_active = 1'b0;
        wait_ticks(17);
        total++;
        if (n[1] - b !== 1) begin
            bad++;
            $display("FAIL ga_off got=%0d want=1", n[1] - b);
        end
        game_active = 1'b1;
        wait_ticks(20);
        total++;
        if (n[1] - b !== 1) begin
            bad++;
            $display("FAIL ga_reenable got=%0d want=1", n[1] - b);
        end
        KEY[1] = 1'b1;
        wait_ticks(5);
        KEY[1] = 1'b0;
        wait_ticks(6);
        KEY[1] = 1'b1;
        wait_ticks(5);
        total++;
        if (n[1] - b !== 2) begin
            bad++;
            $display("FAIL ga_repress got=%0d want=2", n[1] - b);
        end
        total++;
        if (pt[1][b+1] !== t0 + 53) begin
            bad++;
            $display("FAIL ga_repress_tick got=%0d want=%0d",
                     pt[1][b+1], t0 + 53);
        end
    endtask

    task automatic test_reset_mid_hold();
        int b, t0;
        b = n[2];
        wait_ticks(1);
        t0 = tick_num;
        KEY[2] = 1'b0;
        wait_ticks(10);
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (outs !== 4'b0000) begin
            bad++;
            $display("FAIL midreset_outs got=%b want=0000", outs);
        end
        resetn = 1'b1;
        wait_ticks(10);
        KEY[2] = 1'b1;
        wait_ticks(6);
        total++;
        if (n[2] - b !== 2) begin
            bad++;
            $display("FAIL midreset_count got=%0d want=2", n[2] - b);
        end
        total++;
        if (pt[2][b+1] !== t0 + 13) begin
            bad++;
            $display("FAIL midreset_tick got=%0d want=%0d",
                     pt[2][b+1], t0 + 13);
        end
    endtask

    task automatic test_single_cycle();
        total++;
        if (consec !== 0) begin
            bad++;
            $display("FAIL consecutive_pulses got=%0d want=0", consec);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_conflict();
        test_game_active();
        test_reset_mid_hold();
        test_single_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
